dist_uart_reporter: RTL and testbench

DIST_UART_REPORTER -- requirements
Module: dist_uart_reporter

---
 rtl/dist_uart_reporter.sv | 160 ++++++++++++++++
 tb/tb_dist_uart_reporter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_uart_reporter.sv
// Sends each distance sample as three ASCII digits plus CR/LF over an 8N1 UART line.
// Latency: first start bit <= 18 clocks after acceptance; each frame is 10*DIV clocks.
// Backpressure: none; strobes while busy land in a one-deep newest-wins pending slot.
module dist_uart_reporter #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] dist_cm,
    input  logic       dist_valid,
    output logic       tx,
    output logic       tx_busy
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_CNT = CW'(DIV - 2);

    typedef enum logic [1:0] {IDLE, CONV, SEND, NEXT} state_t;
    typedef enum logic [1:0] {C_LOAD, C_HUND, C_TENS} phase_t;

    state_t        state;
    phase_t        phase;
    logic [8:0]    lat;
    logic [8:0]    rem;
    logic [2:0]    hund;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [8:0]    pend_val;
    logic          pend_flag;
    logic [2:0]    char_idx;
    logic [3:0]    bit_idx;
    logic [CW-1:0] baud_cnt;
    logic [7:0]    shreg;

    function automatic logic [7:0] report_char(input logic [2:0] idx, input logic [2:0] h,
                                               input logic [3:0] t, input logic [3:0] o);
        case (idx)
            3'd0:    return {5'b00110, h};
            3'd1:    return {4'h3, t};
            3'd2:    return {4'h3, o};
            3'd3:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= C_LOAD;
            lat       <= '0;
            rem       <= '0;
            hund      <= '0;
            tens      <= '0;
            ones      <= '0;
            pend_val  <= '0;
            pend_flag <= 1'b0;
            char_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            // Any strobe outside IDLE parks in the pending slot; report-start branches below clear it.
            if (dist_valid && state != IDLE) begin
                pend_val  <= dist_cm;
                pend_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (dist_valid || pend_flag) begin
                        lat       <= dist_valid ? dist_cm : pend_val;
                        pend_flag <= 1'b0;
                        phase     <= C_LOAD;
                        tx_busy   <= 1'b1;
                        state     <= CONV;
                    end
                end

                CONV: begin
                    case (phase)
                        C_LOAD: begin
                            rem   <= lat;
                            hund  <= '0;
                            tens  <= '0;
                            phase <= C_HUND;
                        end
                        C_HUND: begin
                            if (rem >= 9'd100) begin
                                rem  <= rem - 9'd100;
                                hund <= hund + 3'd1;
                            end else begin
                                phase <= C_TENS;
                            end
                        end
                        C_TENS: begin
                            if (rem >= 9'd10) begin
                                rem  <= rem - 9'd10;
                                tens <= tens + 4'd1;
                            end else begin
                                ones     <= rem[3:0];
                                char_idx <= '0;
                                shreg    <= report_char(3'd0, hund, tens, rem[3:0]);
                                tx       <= 1'b0;
                                baud_cnt <= '0;
                                bit_idx  <= '0;
                                state    <= SEND;
                            end
                        end
                        default: phase <= C_LOAD;
                    endcase
                end

                SEND: begin
                    if (bit_idx == 4'd9) begin
                        // NEXT owns the final stop-bit clock so the following start bit is back-to-back.
                        if (baud_cnt == STOP_CNT)
                            state <= NEXT;
                        baud_cnt <= baud_cnt + 1'b1;
                    end else if (baud_cnt == LAST_CNT) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 4'd1;
                        if (bit_idx == 4'd8) begin
                            tx <= 1'b1;
                        end else begin
                            tx    <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                NEXT: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (char_idx != 3'd4) begin
                        char_idx <= char_idx + 3'd1;
                        shreg    <= report_char(char_idx + 3'd1, hund, tens, ones);
                        tx       <= 1'b0;
                        state    <= SEND;
                    end else if (dist_valid || pend_flag) begin
                        lat       <= dist_valid ? dist_cm : pend_val;
                        pend_flag <= 1'b0;
                        phase     <= C_LOAD;
                        state     <= CONV;
                    end else begin
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dist_uart_reporter.sv
// Bench for dist_uart_reporter at DIV=10: a line receiver decodes tx and reports are compared
// against digits computed arithmetically from the measurement values.
module tb_dist_uart_reporter;
    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] dist_cm;
    logic       dist_valid;
    logic       tx;
    logic       tx_busy;

    dist_uart_reporter #(.CLK_HZ(1000), .BAUD(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_b[$];
    int         rx_s[$];
    logic       rx_ok[$];
    logic       rx_busy[$];
    int         frames_started = 0;
    int         cur_start = 0;
    int         rd = 0;

    // Line receiver: every sample of every bit must match, so bit widths are checked exactly.
    initial begin
        logic       prev_tx;
        logic [7:0] bv;
        logic       ok;
        logic       ab;
        logic       busy_last;
        int         st;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && prev_tx === 1'b1 && tx === 1'b0) begin
                st = cyc;
                cur_start = cyc;
                frames_started++;
                ok = 1'b1;
                ab = 1'b0;
                bv = '0;
                busy_last = 1'b0;
                for (int b = 0; b < 10 && !ab; b++) begin
                    for (int s = 0; s < 10 && !ab; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (rst === 1'b1) begin
                            ab = 1'b1;
                        end else begin
                            if (s == 0 && b >= 1 && b <= 8) bv[b-1] = tx;
                            else if (b == 0 && tx !== 1'b0) ok = 1'b0;
                            else if (b == 9 && tx !== 1'b1) ok = 1'b0;
                            else if (b >= 1 && b <= 8 && tx !== bv[b-1]) ok = 1'b0;
                            if (b == 9 && s == 9) busy_last = tx_busy;
                        end
                    end
                end
                if (!ab) begin
                    rx_b.push_back(bv);
                    rx_s.push_back(st);
                    rx_ok.push_back(ok);
                    rx_busy.push_back(busy_last);
                end
            end
            prev_tx = tx;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_char(input int v, input int i);
        case (i)
            0:       return 8'(8'h30 + v / 100);
            1:       return 8'(8'h30 + (v / 10) % 10);
            2:       return 8'(8'h30 + v % 10);
            3:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    task automatic pulse(input int v, output int acc);
        @(posedge clk); #1;
        dist_cm    = 9'(v);
        dist_valid = 1'b1;
        @(posedge clk); #1;
        acc        = cyc;
        dist_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k = 0;
        while (frames_started < n && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, frames_started >= n, 1);
    endtask

    // acc < 0 skips the start-latency check (report did not start from IDLE).
    task automatic expect_report(input int v, input int acc, input logic busy_after, input string tag);
        int n = 0;
        logic gaps_ok;
        while (rx_b.size() < rd + 5 && n < 1500) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("%s_complete", tag), rx_b.size() >= rd + 5, 1);
        if (rx_b.size() >= rd + 5) begin
            gaps_ok = 1'b1;
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("%s_char%0d", tag, i), rx_b[rd+i], model_char(v, i));
                chk($sformatf("%s_frame%0d", tag, i), rx_ok[rd+i], 1);
                if (i > 0 && rx_s[rd+i] - rx_s[rd+i-1] != 100) gaps_ok = 1'b0;
            end
            chk($sformatf("%s_back_to_back", tag), gaps_ok, 1);
            chk($sformatf("%s_end_time", tag), cyc, rx_s[rd+4] + 100);
            chk($sformatf("%s_busy_in_stop", tag), rx_busy[rd+4], 1);
            chk($sformatf("%s_busy_after", tag), tx_busy, busy_after);
            if (acc >= 0)
                chk($sformatf("%s_latency", tag), (rx_s[rd] - acc) <= 24 && rx_s[rd] > acc, 1);
            rd += 5;
        end
    endtask

    initial begin
        int acc;
        int dummy;
        int v;
        int fs0;
        int k;
        logic idle_ok;
        int vals[4];

        rst        = 1'b0;
        dist_cm    = '0;
        dist_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_tx", tx, 1);
        chk("idle_busy", tx_busy, 0);

        vals[0] = 123;
        vals[1] = 0;
        vals[2] = 511;
        vals[3] = 9;
        for (int i = 0; i < 4; i++) begin
            pulse(vals[i], acc);
            chk($sformatf("busy_rise_%0d", vals[i]), tx_busy, 1);
            expect_report(vals[i], acc, 1'b0, $sformatf("dir%0d", vals[i]));
        end

        for (int i = 0; i < 4; i++) begin
            v = int'($urandom_range(0, 511));
            pulse(v, acc);
            expect_report(v, acc, 1'b0, $sformatf("rnd%0d", v));
        end

        // Two strobes during a report: only the newest survives.
        pulse(57, acc);
        repeat (100) @(posedge clk);
        pulse(200, dummy);
        repeat (100) @(posedge clk);
        pulse(300, dummy);
        expect_report(57, acc, 1'b1, "p57");
        expect_report(300, -1, 1'b0, "p300");
        repeat (600) @(posedge clk);
        #1;
        chk("no_extra_report", rx_b.size(), rd);

        // Strobe landing on the final stop-bit clock.
        v = int'($urandom_range(0, 511));
        fs0 = frames_started;
        pulse(v, acc);
        wait_frames(fs0 + 5, "wait_last_frame");
        k = cur_start;
        while (cyc < k + 99) begin
            @(posedge clk); #1;
        end
        dist_cm    = 9'd42;
        dist_valid = 1'b1;
        @(posedge clk); #1;
        dist_valid = 1'b0;
        expect_report(v, acc, 1'b1, "pre42");
        expect_report(42, -1, 1'b0, "p42");

        // Reset during the data bits of the second character.
        v = int'($urandom_range(0, 511));
        fs0 = frames_started;
        pulse(v, acc);
        wait_frames(fs0 + 2, "wait_second_frame");
        repeat (25) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midframe_rst_tx", tx, 1);
        chk("midframe_rst_busy", tx_busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rd = rx_b.size();
        fs0 = frames_started;
        idle_ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("post_rst_idle", idle_ok, 1);
        chk("post_rst_no_frames", frames_started, fs0);
        pulse(7, acc);
        chk("busy_rise_7", tx_busy, 1);
        expect_report(7, acc, 1'b0, "p7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
